// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the execute-stage ALU arbiter: word width, ALU control codes,
// requester count and the round-robin pointer type with its grant helper.
package alu_arbiter_pkg;

    localparam int WORD     = 32;
    localparam int ALU_OPW  = 4;
    localparam int ALU_REQS = 2;

    localparam logic [ALU_OPW-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_OPW-1:0] ALU_PASS = 4'b1000;

    typedef enum logic {PRIO_P0 = 1'b0, PRIO_P1 = 1'b1} prio_e;

    // A lone eligible requester always wins; the pointer only breaks ties.
    function automatic logic [ALU_REQS-1:0] rr_grant(input logic [ALU_REQS-1:0] elig,
                                                     input prio_e prio);
        if (&elig) rr_grant = (prio == PRIO_P0) ? 2'b01 : 2'b10;
        else       rr_grant = elig;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel into the ALU arbiter.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int OPW   = ALU_OPW
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_rsp_buf.sv
// One-entry ALU result buffer: load wins over drain so a same-cycle drain+load
// refills without a bubble.
module alu_rsp_buf
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] result_in,
    input  logic             zero_in,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= result_in;
            zero   <= zero_in;
        end else if (drain) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the execute-stage ALU between two requesters, with a
// one-entry result buffer per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     port0,
    alu_arbiter_if.slave     port1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    logic [ALU_REQS-1:0]            req_valid, rsp_valid, rsp_ready, rsp_zero;
    logic [ALU_REQS-1:0]            elig, grant;
    logic [ALU_REQS-1:0][WIDTH-1:0] req_a, req_b, rsp_result;
    logic [ALU_REQS-1:0][OPW-1:0]   req_op;
    prio_e                          prio;

    assign req_valid = {port1.req_valid, port0.req_valid};
    assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};
    assign req_a     = {port1.req_a,  port0.req_a};
    assign req_b     = {port1.req_b,  port0.req_b};
    assign req_op    = {port1.req_op, port0.req_op};

    assign port0.req_ready  = grant[0];
    assign port1.req_ready  = grant[1];
    assign port0.rsp_valid  = rsp_valid[0];
    assign port1.rsp_valid  = rsp_valid[1];
    assign port0.rsp_result = rsp_result[0];
    assign port1.rsp_result = rsp_result[1];
    assign port0.rsp_zero   = rsp_zero[0];
    assign port1.rsp_zero   = rsp_zero[1];

    // A buffer being drained this cycle can take a new result at the same edge.
    assign elig  = req_valid & (~rsp_valid | rsp_ready);
    assign grant = reset ? '0 : rr_grant(elig, prio);

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = OPW'(ALU_PASS);
        if (grant[0]) begin
            alu_a       = req_a[0];
            alu_b       = req_b[0];
            alu_control = req_op[0];
        end else if (grant[1]) begin
            alu_a       = req_a[1];
            alu_b       = req_b[1];
            alu_control = req_op[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         prio <= PRIO_P0;
        else if (grant[0]) prio <= PRIO_P1;
        else if (grant[1]) prio <= PRIO_P0;
    end

    for (genvar i = 0; i < ALU_REQS; i++) begin : g_buf
        alu_rsp_buf #(.WIDTH(WIDTH)) u_buf (
            .clk       (clk),
            .rst       (reset),
            .load      (grant[i]),
            .drain     (rsp_ready[i]),
            .result_in (alu_result),
            .zero_in   (alu_zero),
            .valid     (rsp_valid[i]),
            .result    (rsp_result[i]),
            .zero      (rsp_zero[i])
        );
    end

endmodule
